// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side signal bundle for fifo_wr_arbiter.
// master: arbiter side; slave: requesters and FIFO driving the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int DWIDTH = 4,
  parameter int NREQ   = 4
);
  localparam int GW = $clog2(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DWIDTH-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   full;
  logic                   write_en;
  logic [DWIDTH-1:0]      data_in;
  logic [GW-1:0]          grant_id;
  logic                   busy;

  modport master (
    input  req_valid, req_data, full,
    output req_ready, write_en, data_in, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, full,
    input  req_ready, write_en, data_in, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter funnelling NREQ requesters into one FIFO write port.
// Define FIFO_ARB_BURST_EN for multi-beat grants of up to BURST_MAX beats; otherwise one beat per grant.
module fifo_wr_arbiter #(
  parameter int DWIDTH    = 4,
  parameter int NREQ      = 4,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  fifo_wr_arbiter_if.master bus
);
  localparam int GW = $clog2(NREQ);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      r_state, w_state_nxt;
  logic [GW-1:0] r_grant_id, r_last_grant, w_pick;
  logic        w_any_valid, w_valid_g, w_xfer, w_done, w_last_beat;
  int unsigned w_idx;

  // Scan downward so the lowest offset from last_grant+1 is the final (winning) assignment.
  always_comb begin
    w_pick      = r_last_grant;
    w_any_valid = 1'b0;
    w_idx       = 0;
    for (int unsigned i = NREQ; i >= 1; i--) begin
      w_idx = (int'(r_last_grant) + i) % NREQ;
      if (bus.req_valid[w_idx]) begin
        w_pick      = GW'(w_idx);
        w_any_valid = 1'b1;
      end
    end
  end

  assign w_valid_g = bus.req_valid[r_grant_id];
  assign w_xfer    = (r_state == GRANT) && w_valid_g && !bus.full && !rst;

`ifdef FIFO_ARB_BURST_EN
  localparam int CW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

  logic [CW-1:0] r_beat_cnt;

  assign w_last_beat = (r_beat_cnt == CW'(BURST_MAX - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_beat_cnt <= '0;
    end else if (w_xfer) begin
      r_beat_cnt <= r_beat_cnt + 1'b1;
    end
  end
`else
  assign w_last_beat = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_valid) w_state_nxt = GRANT;
      end
      GRANT: begin
        w_done = !w_valid_g || (w_xfer && w_last_beat);
        if (w_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant_id   <= '0;
      r_last_grant <= GW'(NREQ - 1);
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_any_valid) r_grant_id <= w_pick;
      if (r_state == GRANT && w_done) r_last_grant <= r_grant_id;
    end
  end

  // Outputs are gated by rst directly so they drop within the reset cycle.
  always_comb begin
    bus.req_ready = '0;
    if (r_state == GRANT && !bus.full && !rst) bus.req_ready[r_grant_id] = 1'b1;
  end

  assign bus.write_en = w_xfer;
  assign bus.data_in  = rst ? '0 : bus.req_data[int'(r_grant_id)*DWIDTH +: DWIDTH];
  assign bus.grant_id = r_grant_id;
  assign bus.busy     = (r_state == GRANT) && !rst;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed corner sequences, randomized run vs reference model.
module tb_fifo_wr_arbiter;
  localparam int DW = 4;
  localparam int NR = 4;
  localparam int BM = 4;
`ifdef FIFO_ARB_BURST_EN
  localparam int EB = BM;
`else
  localparam int EB = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.DWIDTH(DW), .NREQ(NR)) bus ();

  fifo_wr_arbiter #(.DWIDTH(DW), .NREQ(NR), .BURST_MAX(BM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner<0 means no grant is held.
  int m_owner, m_beats, m_last, m_gid;
  logic [NR-1:0]    cur_v;
  logic [NR*DW-1:0] cur_d;
  logic             cur_f;

  task automatic model_reset();
    m_owner = -1;
    m_beats = 0;
    m_last  = NR - 1;
    m_gid   = 0;
  endtask

  task automatic drive(input logic [NR-1:0] v, input logic [NR*DW-1:0] d, input logic f);
    cur_v = v; cur_d = d; cur_f = f;
    bus.req_valid = v;
    bus.req_data  = d;
    bus.full      = f;
  endtask

  task automatic model_cycle();
    int exp_busy, exp_rdy, exp_wr;
    exp_busy = (m_owner >= 0) ? 1 : 0;
    exp_rdy  = (m_owner >= 0 && !cur_f) ? (1 << m_owner) : 0;
    exp_wr   = (m_owner >= 0 && !cur_f && cur_v[m_owner]) ? 1 : 0;
    check("busy", int'(bus.busy), exp_busy);
    check("req_ready", int'(bus.req_ready), exp_rdy);
    check("write_en", int'(bus.write_en), exp_wr);
    check("grant_id", int'(bus.grant_id), m_gid);
    check("data_in", int'(bus.data_in), int'(cur_d[m_gid*DW +: DW]));
    if (m_owner < 0) begin
      for (int k = 1; k <= NR; k++) begin
        int c;
        c = (m_last + k) % NR;
        if (cur_v[c]) begin
          m_owner = c; m_gid = c; m_beats = 0;
          break;
        end
      end
    end else begin
      if (exp_wr != 0) m_beats++;
      if (!cur_v[m_owner] || m_beats == EB) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [NR-1:0] v, input logic [NR*DW-1:0] d, input logic f);
    drive(v, d, f);
    #3;
    model_cycle();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive('1, '1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_write_en", int'(bus.write_en), 0);
    check("rst_req_ready", int'(bus.req_ready), 0);
    check("rst_data_in", int'(bus.data_in), 0);
    check("rst_grant_id", int'(bus.grant_id), 0);
    rst = 1'b0;
    drive('0, '0, 1'b0);
    model_reset();
  endtask

  // Invariants checked every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      check("inv_wr_while_full", int'(bus.write_en && bus.full), 0);
      check("inv_ready_onehot0", int'($onehot0(bus.req_ready)), 1);
      if (bus.write_en)
        check("inv_data_pass", int'(bus.data_in), int'(bus.req_data[int'(bus.grant_id)*DW +: DW]));
    end
  end

  typedef struct {
    logic [NR-1:0]    v;
    logic [NR*DW-1:0] d;
    logic             wr;
    logic [DW-1:0]    data;
    logic             busy;
    logic [NR-1:0]    rdy;
  } vec_t;

  function automatic vec_t mk(input logic [NR-1:0] v, input logic [DW-1:0] d0,
                              input logic wr, input logic busy, input logic [NR-1:0] rdy);
    vec_t r;
    r.v = v; r.d = {{(NR-1)*DW{1'b0}}, d0}; r.wr = wr; r.data = d0; r.busy = busy; r.rdy = rdy;
    return r;
  endfunction

  initial begin
    vec_t tbl[$];
    int   order[$];
    int   wr_cnt, first_cnt;
    logic prev_busy, in_first;
    logic [NR-1:0]    rv;
    logic [NR*DW-1:0] rd;

    // Requester 0 streams beats 1..6, then drops valid.
`ifdef FIFO_ARB_BURST_EN
    tbl.push_back(mk(4'b0001, 4'h1, 0, 0, 4'b0000));
    tbl.push_back(mk(4'b0001, 4'h1, 1, 1, 4'b0001));
    tbl.push_back(mk(4'b0001, 4'h2, 1, 1, 4'b0001));
    tbl.push_back(mk(4'b0001, 4'h3, 1, 1, 4'b0001));
    tbl.push_back(mk(4'b0001, 4'h4, 1, 1, 4'b0001));
    tbl.push_back(mk(4'b0001, 4'h5, 0, 0, 4'b0000));
    tbl.push_back(mk(4'b0001, 4'h5, 1, 1, 4'b0001));
    tbl.push_back(mk(4'b0001, 4'h6, 1, 1, 4'b0001));
    tbl.push_back(mk(4'b0000, 4'h0, 0, 1, 4'b0001));
    tbl.push_back(mk(4'b0000, 4'h0, 0, 0, 4'b0000));
`else
    for (int b = 1; b <= 6; b++) begin
      tbl.push_back(mk(4'b0001, 4'(b), 0, 0, 4'b0000));
      tbl.push_back(mk(4'b0001, 4'(b), 1, 1, 4'b0001));
    end
    tbl.push_back(mk(4'b0000, 4'h0, 0, 0, 4'b0000));
    tbl.push_back(mk(4'b0000, 4'h0, 0, 0, 4'b0000));
`endif

    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, 1'b0);
      #3;
      check($sformatf("vec%0d_write_en", i), int'(bus.write_en), int'(tbl[i].wr));
      check($sformatf("vec%0d_busy", i), int'(bus.busy), int'(tbl[i].busy));
      check($sformatf("vec%0d_req_ready", i), int'(bus.req_ready), int'(tbl[i].rdy));
      if (tbl[i].wr) check($sformatf("vec%0d_data_in", i), int'(bus.data_in), int'(tbl[i].data));
      model_cycle();
      tick();
    end

    // All requesters continuously valid: round-robin order and write density.
    do_reset();
    wr_cnt = 0;
    prev_busy = 1'b0;
    for (int c = 0; c < 25; c++) begin
      drive('1, {4'hB, 4'hA, 4'h9, 4'h8}, 1'b0);
      #3;
      if (bus.busy && !prev_busy) order.push_back(int'(bus.grant_id));
      prev_busy = bus.busy;
      if (c >= 1 && c <= 20 && bus.write_en) wr_cnt++;
      model_cycle();
      tick();
    end
    check("rr_grant_count_ok", int'(order.size() >= 5), 1);
    for (int i = 0; i < 5 && i < order.size(); i++)
      check($sformatf("rr_order%0d", i), order[i], i % NR);
    check("rr_write_density", wr_cnt, 20 * EB / (EB + 1));

    // Requester 2 stalled by full for three cycles mid-burst.
    do_reset();
    first_cnt = 0;
    in_first = 1'b1;
    prev_busy = 1'b0;
    for (int c = 0; c < 14; c++) begin
      drive(4'b0100, NR*DW'($urandom), (c >= 3 && c <= 5));
      #3;
      if (in_first && prev_busy && !bus.busy) in_first = 1'b0;
      if (in_first && bus.write_en) first_cnt++;
      prev_busy = bus.busy;
      model_cycle();
      tick();
    end
    check("stall_burst_beats", first_cnt, EB);

    // Asynchronous reset pulsed mid-grant, then all requesters valid.
    do_reset();
    for (int c = 0; c < 3; c++) step(4'b0010, {4'h0, 4'h0, 4'h7, 4'h0}, 1'b0);
    drive(4'b0010, {4'h0, 4'h0, 4'h7, 4'h0}, 1'b0);
    #3;
    check("pre_rst_busy", int'(bus.busy), 1);
    check("pre_rst_grant_id", int'(bus.grant_id), 1);
    rst = 1'b1;
    #1;
    check("async_rst_write_en", int'(bus.write_en), 0);
    check("async_rst_busy", int'(bus.busy), 0);
    check("async_rst_req_ready", int'(bus.req_ready), 0);
    check("async_rst_data_in", int'(bus.data_in), 0);
    tick();
    rst = 1'b0;
    model_reset();
    step('1, {4'h4, 4'h3, 4'h2, 4'h1}, 1'b0);
    drive('1, {4'h4, 4'h3, 4'h2, 4'h1}, 1'b0);
    #3;
    check("post_rst_first_winner", int'(bus.grant_id), 0);
    model_cycle();
    tick();

    // Randomized traffic with persistent valids and random backpressure.
    do_reset();
    rv = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++)
        if ($urandom_range(0, 3) == 0) rv[i] = ~rv[i];
      rd = NR*DW'($urandom);
      step(rv, rd, ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
